// File: rtl/sdp_nrdma_eg_roc_consumer.sv
// Read-order context consumer: frames DMA response beats into groups using
// contexts popped from the RO cfifo, with a registered valid/ready output.
module sdp_nrdma_eg_roc_consumer #(
    parameter int DW   = 64,
    parameter int CNTW = 16
) (
    input  logic            nvdla_core_clk,
    input  logic            nvdla_core_rst,
    input  logic            roc_rd_pvld,
    output logic            roc_rd_prdy,
    input  logic [3:0]      roc_rd_pd,
    input  logic            dma_rsp_pvld,
    output logic            dma_rsp_prdy,
    input  logic [DW-1:0]   dma_rsp_pd,
    output logic            eg_out_pvld,
    input  logic            eg_out_prdy,
    output logic [DW-1:0]   eg_out_pd,
    output logic            eg_out_last,
    output logic            eg_out_eos,
    output logic [CNTW-1:0] grp_done_cnt,
    output logic            eg_idle
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [2:0]      ctx_len_q, ctx_len_d;
    logic            ctx_eos_q, ctx_eos_d;
    logic [2:0]      beat_cnt_q, beat_cnt_d;
    logic            out_vld_q, out_vld_d;
    logic [DW-1:0]   out_pd_q, out_pd_d;
    logic            out_last_q, out_last_d;
    logic            out_eos_q, out_eos_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic acc, lastb, pop, grp_fire;

    // The output slot is free when empty or being drained this cycle.
    assign dma_rsp_prdy = (state_q == RUN) & (!out_vld_q | eg_out_prdy);
    assign acc          = dma_rsp_pvld & dma_rsp_prdy;
    assign lastb        = acc & (beat_cnt_q == ctx_len_q);
    assign roc_rd_prdy  = !nvdla_core_rst & ((state_q == IDLE) | lastb);
    assign pop          = roc_rd_pvld & roc_rd_prdy;
    assign grp_fire     = out_vld_q & eg_out_prdy & out_last_q;

    assign eg_out_pvld  = out_vld_q;
    assign eg_out_pd    = out_pd_q;
    assign eg_out_last  = out_last_q;
    assign eg_out_eos   = out_eos_q;
    assign grp_done_cnt = cnt_q;
    assign eg_idle      = (state_q == IDLE) & !out_vld_q;

    always_comb begin
        state_d    = state_q;
        ctx_len_d  = ctx_len_q;
        ctx_eos_d  = ctx_eos_q;
        beat_cnt_d = beat_cnt_q;
        out_vld_d  = out_vld_q;
        out_pd_d   = out_pd_q;
        out_last_d = out_last_q;
        out_eos_d  = out_eos_q;
        cnt_d      = cnt_q;

        // A pop in RUN only happens alongside lastb, so both cases reload here.
        if (pop) begin
            state_d    = RUN;
            ctx_len_d  = roc_rd_pd[2:0];
            ctx_eos_d  = roc_rd_pd[3];
            beat_cnt_d = 3'd0;
        end else if (lastb) begin
            state_d    = IDLE;
            beat_cnt_d = 3'd0;
        end else if (acc) begin
            beat_cnt_d = beat_cnt_q + 3'd1;
        end

        if (acc) begin
            out_vld_d  = 1'b1;
            out_pd_d   = dma_rsp_pd;
            out_last_d = (beat_cnt_q == ctx_len_q);
            out_eos_d  = (beat_cnt_q == ctx_len_q) & ctx_eos_q;
        end else if (out_vld_q & eg_out_prdy) begin
            out_vld_d  = 1'b0;
        end

        if (grp_fire && (cnt_q != {CNTW{1'b1}})) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state_q    <= IDLE;
            ctx_len_q  <= 3'd0;
            ctx_eos_q  <= 1'b0;
            beat_cnt_q <= 3'd0;
            out_vld_q  <= 1'b0;
            out_pd_q   <= '0;
            out_last_q <= 1'b0;
            out_eos_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ctx_len_q  <= ctx_len_d;
            ctx_eos_q  <= ctx_eos_d;
            beat_cnt_q <= beat_cnt_d;
            out_vld_q  <= out_vld_d;
            out_pd_q   <= out_pd_d;
            out_last_q <= out_last_d;
            out_eos_q  <= out_eos_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sdp_nrdma_eg_roc_consumer.sv
// Bench for sdp_nrdma_eg_roc_consumer: queue-based source models and a
// group-level scoreboard of expected output beats.
module tb_sdp_nrdma_eg_roc_consumer;

    logic        clk = 1'b0;
    logic        rst;
    logic        roc_rd_pvld, roc_rd_prdy;
    logic [3:0]  roc_rd_pd;
    logic        dma_rsp_pvld, dma_rsp_prdy;
    logic [63:0] dma_rsp_pd;
    logic        eg_out_pvld, eg_out_prdy;
    logic [63:0] eg_out_pd;
    logic        eg_out_last, eg_out_eos;
    logic [15:0] grp_done_cnt;
    logic        eg_idle;

    always #5 clk = ~clk;

    sdp_nrdma_eg_roc_consumer #(.DW(64), .CNTW(16)) dut (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst),
        .roc_rd_pvld(roc_rd_pvld), .roc_rd_prdy(roc_rd_prdy), .roc_rd_pd(roc_rd_pd),
        .dma_rsp_pvld(dma_rsp_pvld), .dma_rsp_prdy(dma_rsp_prdy), .dma_rsp_pd(dma_rsp_pd),
        .eg_out_pvld(eg_out_pvld), .eg_out_prdy(eg_out_prdy), .eg_out_pd(eg_out_pd),
        .eg_out_last(eg_out_last), .eg_out_eos(eg_out_eos),
        .grp_done_cnt(grp_done_cnt), .eg_idle(eg_idle)
    );

    typedef struct packed {logic [63:0] pd; logic last; logic eos;} beat_t;
    typedef struct {logic [3:0] ctx; logic [15:0] pat; int beats; int eos;} vec_t;

    logic [3:0]  ctxq[$];
    logic [63:0] datq[$];
    logic [63:0] mdl_dat[$];
    beat_t       expq[$];
    int          roc_cycs[$], rsp_cycs[$], out_cycs[$];

    int n_chk = 0, n_err = 0;
    int cyc = 0, nout = 0, neos = 0;
    int grp_exp = 0;
    int prdy_mode = 0;
    logic [15:0] pat = 16'hFFFF;
    bit src_rand = 0;
    bit stl_v = 0;
    beat_t stl;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic push_dat(logic [63:0] d);
        datq.push_back(d);
        mdl_dat.push_back(d);
    endtask

    // A context of value c covers c[2:0]+1 beats; the last one carries eos if c[3].
    task automatic push_ctx(logic [3:0] c);
        int n;
        beat_t b;
        n = int'(c[2:0]) + 1;
        ctxq.push_back(c);
        for (int i = 0; i < n; i++) begin
            b.pd   = mdl_dat.pop_front();
            b.last = (i == n - 1);
            b.eos  = (i == n - 1) && c[3];
            expq.push_back(b);
        end
    endtask

    task automatic push_group(logic [3:0] c, logic [63:0] base);
        for (int i = 0; i <= int'(c[2:0]); i++) push_dat(base + 64'(i));
        push_ctx(c);
    endtask

    task automatic drive();
        bit re, de;
        re = src_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        de = src_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        roc_rd_pvld  = re && (ctxq.size() != 0);
        roc_rd_pd    = (ctxq.size() != 0) ? ctxq[0] : 4'h0;
        dma_rsp_pvld = de && (datq.size() != 0);
        dma_rsp_pd   = (datq.size() != 0) ? datq[0] : 64'h0;
        case (prdy_mode)
            1:       eg_out_prdy = pat[cyc[3:0]];
            2:       eg_out_prdy = ($urandom_range(0, 2) != 0);
            default: eg_out_prdy = 1'b1;
        endcase
    endtask

    task automatic settle();
        drive();
        #1;
    endtask

    // Evaluates handshakes on settled inputs, crosses one clock edge, re-drives.
    task automatic tick();
        bit rf, df, of_;
        beat_t e;
        rf  = roc_rd_pvld & roc_rd_prdy;
        df  = dma_rsp_pvld & dma_rsp_prdy;
        of_ = eg_out_pvld & eg_out_prdy;
        if (!rst) begin
            if (stl_v) begin
                chk("stall_pvld", 64'(eg_out_pvld), 64'd1);
                chk("stall_pd", eg_out_pd, stl.pd);
                chk("stall_last_eos", {eg_out_last, eg_out_eos}, {stl.last, stl.eos});
            end
            if (of_) begin
                if (expq.size() == 0) begin
                    chk("unexpected_beat", 64'(eg_out_pvld), 64'd0);
                end else begin
                    e = expq.pop_front();
                    chk("out_pd", eg_out_pd, e.pd);
                    chk("out_last_eos", {eg_out_last, eg_out_eos}, {e.last, e.eos});
                    if (e.last && grp_exp < 65535) grp_exp++;
                    if (e.eos) neos++;
                end
                nout++;
                out_cycs.push_back(cyc);
            end
            if (rf) begin
                void'(ctxq.pop_front());
                roc_cycs.push_back(cyc);
            end
            if (df) begin
                void'(datq.pop_front());
                rsp_cycs.push_back(cyc);
            end
            stl_v   = eg_out_pvld & !eg_out_prdy;
            stl.pd  = eg_out_pd;
            stl.last = eg_out_last;
            stl.eos = eg_out_eos;
        end else begin
            stl_v = 0;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        settle();
    endtask

    task automatic drain(string nm, int maxc);
        int k;
        k = 0;
        while ((expq.size() != 0 || ctxq.size() != 0 || datq.size() != 0 || eg_out_pvld) && k < maxc) begin
            tick();
            k++;
        end
        chk({nm, "_timeout"}, 64'(k < maxc), 64'd1);
    endtask

    task automatic clear_cycs();
        roc_cycs.delete();
        rsp_cycs.delete();
        out_cycs.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[4];
        int   n0, e0, k;
        bit   bad;
        int   tot;

        vt[0] = '{ctx: 4'h7, pat: 16'hAAAA, beats: 8, eos: 0};
        vt[1] = '{ctx: 4'h3, pat: 16'hFFFF, beats: 4, eos: 0};
        vt[2] = '{ctx: 4'hC, pat: 16'h3333, beats: 5, eos: 1};
        vt[3] = '{ctx: 4'h8, pat: 16'h5555, beats: 1, eos: 1};

        // Reset with a context waiting.
        rst = 1'b1;
        roc_rd_pvld = 0; roc_rd_pd = 0; dma_rsp_pvld = 0; dma_rsp_pd = 0; eg_out_prdy = 1;
        push_dat(64'hAAAA_0000_0000_000A);
        push_dat(64'hBBBB_0000_0000_000B);
        push_dat(64'hCCCC_0000_0000_000C);
        push_ctx(4'h2);
        @(negedge clk);
        settle();
        for (int i = 0; i < 3; i++) tick();
        chk("rst_roc_prdy", 64'(roc_rd_prdy), 64'd0);
        chk("rst_rsp_prdy", 64'(dma_rsp_prdy), 64'd0);
        chk("rst_pvld", 64'(eg_out_pvld), 64'd0);
        chk("rst_pd", eg_out_pd, 64'd0);
        chk("rst_last_eos", {eg_out_last, eg_out_eos}, 2'b00);
        chk("rst_cnt", 64'(grp_done_cnt), 64'd0);
        chk("rst_idle", 64'(eg_idle), 64'd1);
        chk("rst_roc_pvld_held", 64'(roc_rd_pvld), 64'd1);
        rst = 1'b0;
        settle();
        chk("release_roc_prdy", 64'(roc_rd_prdy), 64'd1);
        clear_cycs();

        // Three-beat group at full rate.
        drain("g3", 50);
        chk("g3_pop_to_prdy", 64'(rsp_cycs[0] - roc_cycs[0]), 64'd1);
        chk("g3_acc_to_out", 64'(out_cycs[0] - rsp_cycs[0]), 64'd1);
        chk("g3_consecutive", 64'(out_cycs[2] - out_cycs[0]), 64'd2);
        chk("g3_cnt", 64'(grp_done_cnt), 64'd1);
        chk("g3_idle", 64'(eg_idle), 64'd1);

        // Back-to-back contexts 0 then 9.
        clear_cycs();
        push_group(4'h0, 64'h1000);
        push_group(4'h9, 64'h2000);
        settle();
        drain("b2b", 50);
        chk("b2b_pop_same_cycle", 64'(roc_cycs[1]), 64'(rsp_cycs[0]));
        chk("b2b_no_bubble", 64'(out_cycs[2] - out_cycs[0]), 64'd2);
        chk("b2b_cnt", 64'(grp_done_cnt), 64'd3);

        // Table of single groups under output backpressure patterns.
        prdy_mode = 1;
        foreach (vt[i]) begin
            n0 = nout;
            e0 = neos;
            pat = vt[i].pat;
            push_group(vt[i].ctx, 64'h3000 + 64'(i * 16));
            settle();
            drain("vec", 200);
            chk("vec_beats", 64'(nout - n0), 64'(vt[i].beats));
            chk("vec_eos", 64'(neos - e0), 64'(vt[i].eos));
            chk("vec_cnt", 64'(grp_done_cnt), 64'(grp_exp));
            chk("vec_idle", 64'(eg_idle), 64'd1);
        end
        prdy_mode = 0;

        // Response data with no context must not be consumed.
        n0 = nout;
        push_dat(64'h4000);
        push_dat(64'h4001);
        settle();
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (dma_rsp_prdy || eg_out_pvld) bad = 1;
            tick();
        end
        chk("noctx_stalled", 64'(bad), 64'd0);
        chk("noctx_rsp_pvld", 64'(dma_rsp_pvld), 64'd1);
        push_ctx(4'h1);
        settle();
        drain("noctx", 50);
        chk("noctx_beats", 64'(nout - n0), 64'd2);

        // Reset after the second beat of a five-beat group.
        clear_cycs();
        push_group(4'h4, 64'h5000);
        settle();
        k = 0;
        while (rsp_cycs.size() < 2 && k < 50) begin
            tick();
            k++;
        end
        chk("midrst_reach", 64'(k < 50), 64'd1);
        rst = 1'b1;
        settle();
        tick();
        chk("midrst_pvld", 64'(eg_out_pvld), 64'd0);
        chk("midrst_idle", 64'(eg_idle), 64'd1);
        chk("midrst_roc_prdy", 64'(roc_rd_prdy), 64'd0);
        ctxq.delete(); datq.delete(); mdl_dat.delete(); expq.delete();
        grp_exp = 0;
        rst = 1'b0;
        n0 = nout;
        push_group(4'h0, 64'h6000);
        settle();
        drain("postrst", 50);
        chk("postrst_beats", 64'(nout - n0), 64'd1);
        chk("postrst_cnt", 64'(grp_done_cnt), 64'd1);

        // Randomized traffic with source gaps and random output backpressure.
        src_rand = 1;
        prdy_mode = 2;
        n0 = nout;
        tot = 0;
        for (int g = 0; g < 60; g++) begin
            logic [3:0] c;
            c = 4'($urandom_range(0, 15));
            tot += int'(c[2:0]) + 1;
            for (int i = 0; i <= int'(c[2:0]); i++) push_dat({$urandom, $urandom});
            push_ctx(c);
        end
        settle();
        drain("rand", 5000);
        chk("rand_beats", 64'(nout - n0), 64'(tot));
        chk("rand_cnt", 64'(grp_done_cnt), 64'(grp_exp));
        chk("rand_idle", 64'(eg_idle), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
